// File: rtl/sram_1rw1r_wmask_model.sv
// Behavioural 1RW+1R SRAM: byte-lane write mask, READ_LATENCY-deep read
// pipelines with valid strobes, same-address write/read collision flag.
//
// Ports:
//   clk, rstb            clock, async active-low reset
//   csb0/web0/wmask0     port 0 select, write enable, lane enables
//   addr0/din0/dout0     port 0 address, write data, read data
//   dout0_valid          port 0 read data valid pulse
//   csb1/addr1/dout1     port 1 select, address, read data
//   dout1_valid          port 1 read data valid pulse
//   collision            port 1 read returned pre-write data
module sram_1rw1r_wmask_model #(
  parameter int DATA_WIDTH   = 128,
  parameter int ADDR_WIDTH   = 10,
  parameter int NUM_WMASK    = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASK-1:0]  wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  collision
);

  localparam int LW    = DATA_WIDTH / NUM_WMASK;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LAST  = READ_LATENCY - 1;

  if (DATA_WIDTH % NUM_WMASK != 0) begin : g_bad_width
    $fatal(1, "DATA_WIDTH must be a multiple of NUM_WMASK");
  end

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
    $fatal(1, "READ_LATENCY must be in 1..4");
  end

  typedef struct packed {
    logic                  v;
    logic                  c;
    logic [DATA_WIDTH-1:0] d;
  } stg_t;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  stg_t p0_q [READ_LATENCY];
  stg_t p1_q [READ_LATENCY];
  stg_t p0_d;
  stg_t p1_d;

  logic [DATA_WIDTH-1:0] dout0_q;
  logic [DATA_WIDTH-1:0] dout1_q;
  logic                  dv0_q;
  logic                  dv1_q;
  logic                  coll_q;

  logic wr_en;
  logic rd0_en;
  logic rd1_en;
  logic coll;

  assign wr_en  = !csb0 && !web0;
  assign rd0_en = !csb0 && web0;
  assign rd1_en = !csb1;
  assign coll   = rd1_en && wr_en &&
                  (addr0 == addr1) && (|wmask0);

  // Array is deliberately never reset; gating on rstb drops
  // writes presented while reset is held.
  always_ff @(posedge clk) begin
    if (rstb && wr_en) begin
      for (int i = 0; i < NUM_WMASK; i++) begin
        if (wmask0[i]) begin
          mem_q[addr0][i*LW +: LW] <= din0[i*LW +: LW];
        end
      end
    end
  end

  // Reads see mem_q before this edge's write lands.
  always_comb begin
    p0_d   = '0;
    p1_d   = '0;
    p0_d.v = rd0_en;
    p1_d.v = rd1_en;
    p1_d.c = coll;
    if (rd0_en) p0_d.d = mem_q[addr0];
    if (rd1_en) p1_d.d = mem_q[addr1];
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        p0_q[i] <= '0;
        p1_q[i] <= '0;
      end
      dout0_q <= '0;
      dout1_q <= '0;
      dv0_q   <= 1'b0;
      dv1_q   <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      p0_q[0] <= p0_d;
      p1_q[0] <= p1_d;
      for (int i = 1; i < READ_LATENCY; i++) begin
        p0_q[i] <= p0_q[i-1];
        p1_q[i] <= p1_q[i-1];
      end
      dv0_q  <= p0_q[LAST].v;
      dv1_q  <= p1_q[LAST].v;
      coll_q <= p1_q[LAST].v & p1_q[LAST].c;
      if (p0_q[LAST].v) dout0_q <= p0_q[LAST].d;
      if (p1_q[LAST].v) dout1_q <= p1_q[LAST].d;
    end
  end

  assign dout0       = dout0_q;
  assign dout1       = dout1_q;
  assign dout0_valid = dv0_q;
  assign dout1_valid = dv1_q;
  assign collision   = coll_q;

endmodule

// File: tb/tb_sram_1rw1r_wmask_model.sv
// Randomised bench for sram_1rw1r_wmask_model at READ_LATENCY 1 and 3,
// both instances driven in lockstep and checked against an array model.
module tb_sram_1rw1r_wmask_model;

  localparam int DW = 128;
  localparam int AW = 10;
  localparam int NW = 16;
  localparam int NC = 1024;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          csb0 = 1'b1;
  logic          web0 = 1'b1;
  logic          csb1 = 1'b1;
  logic [NW-1:0] wmask0 = '0;
  logic [AW-1:0] addr0 = '0;
  logic [AW-1:0] addr1 = '0;
  logic [DW-1:0] din0 = '0;

  logic [DW-1:0] dout0 [2];
  logic [DW-1:0] dout1 [2];
  logic          dv0 [2];
  logic          dv1 [2];
  logic          coll [2];

  always #5 clk = ~clk;

  sram_1rw1r_wmask_model #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .NUM_WMASK(NW), .READ_LATENCY(1)
  ) u_l1 (
    .clk(clk), .rstb(rstb),
    .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0),
    .dout0(dout0[0]), .dout0_valid(dv0[0]),
    .csb1(csb1), .addr1(addr1),
    .dout1(dout1[0]), .dout1_valid(dv1[0]),
    .collision(coll[0])
  );

  sram_1rw1r_wmask_model #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .NUM_WMASK(NW), .READ_LATENCY(3)
  ) u_l3 (
    .clk(clk), .rstb(rstb),
    .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0),
    .dout0(dout0[1]), .dout0_valid(dv0[1]),
    .csb1(csb1), .addr1(addr1),
    .dout1(dout1[1]), .dout1_valid(dv1[1]),
    .collision(coll[1])
  );

  int total = 0;
  int bad = 0;
  int k = 0;

  logic [DW-1:0] mdl [16];
  bit            rv0 [NC];
  bit            rv1 [NC];
  bit            rc  [NC];
  logic [DW-1:0] rd0 [NC];
  logic [DW-1:0] rd1 [NC];
  logic [DW-1:0] e_d0 [2];
  logic [DW-1:0] e_d1 [2];

  task automatic check(input string tag,
                       input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic verify();
    int j;
    bit v0, v1, c;
    string p;
    for (int i = 0; i < 2; i++) begin
      j  = k - ((i == 0) ? 1 : 3);
      v0 = 1'b0;
      v1 = 1'b0;
      c  = 1'b0;
      if (j >= 0) begin
        v0 = rv0[j];
        v1 = rv1[j];
        c  = rc[j];
        if (v0) e_d0[i] = rd0[j];
        if (v1) e_d1[i] = rd1[j];
      end
      p = (i == 0) ? "L1" : "L3";
      check({p, " dout0_valid"}, DW'(dv0[i]), DW'(v0));
      check({p, " dout0"}, dout0[i], e_d0[i]);
      check({p, " dout1_valid"}, DW'(dv1[i]), DW'(v1));
      check({p, " dout1"}, dout1[i], e_d1[i]);
      check({p, " collision"}, DW'(coll[i]), DW'(c));
    end
  endtask

  task automatic step(input logic c0, input logic w0,
                      input logic [NW-1:0] m,
                      input logic [AW-1:0] a0,
                      input logic [DW-1:0] d,
                      input logic c1,
                      input logic [AW-1:0] a1);
    csb0 = c0; web0 = w0; wmask0 = m;
    addr0 = a0; din0 = d;
    csb1 = c1; addr1 = a1;
    @(posedge clk);
    rv0[k] = 1'b0; rv1[k] = 1'b0; rc[k] = 1'b0;
    rd0[k] = '0; rd1[k] = '0;
    if (rstb) begin
      if (!c0 && w0) begin
        rv0[k] = 1'b1;
        rd0[k] = mdl[a0[3:0]];
      end
      if (!c1) begin
        rv1[k] = 1'b1;
        rd1[k] = mdl[a1[3:0]];
        rc[k]  = !c0 && !w0 && (a0 == a1) && (m != '0);
      end
      if (!c0 && !w0) begin
        for (int i = 0; i < NW; i++)
          if (m[i]) mdl[a0[3:0]][i*8 +: 8] = d[i*8 +: 8];
      end
    end
    #1;
    verify();
    k++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, 1'b1, '0, '0, '0, 1'b1, '0);
  endtask

  task automatic rand_step(input logic allow_rst);
    logic [NW-1:0] m;
    case ($urandom_range(0, 2))
      0:       m = '0;
      1:       m = '1;
      default: m = NW'($urandom);
    endcase
    step($urandom_range(0, 3) == 0, 1'($urandom),
         m, AW'($urandom_range(0, 7)), rnd(),
         $urandom_range(0, 2) == 0,
         AW'($urandom_range(0, 7)));
    if (allow_rst) begin end
  endtask

  task automatic reset_mid();
    #2;
    rstb = 1'b0;
    #1;
    for (int i = 0; i < NC; i++) begin
      rv0[i] = 1'b0;
      rv1[i] = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      e_d0[i] = '0;
      e_d1[i] = '0;
      check("rst dout0", dout0[i], '0);
      check("rst dout1", dout1[i], '0);
      check("rst valid0", DW'(dv0[i]), '0);
      check("rst valid1", DW'(dv1[i]), '0);
      check("rst collision", DW'(coll[i]), '0);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      e_d0[i] = '0;
      e_d1[i] = '0;
    end
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    rstb = 1'b0;
    idle(2);
    rstb = 1'b1;
    for (int a = 0; a < 16; a++)
      step(1'b0, 1'b0, '1, AW'(a), rnd(), 1'b1, '0);
    // full-mask write then port 0 read
    step(1'b0, 1'b0, '1, AW'(3), {16{8'hA5}}, 1'b1, '0);
    step(1'b0, 1'b1, '0, AW'(3), '0, 1'b1, '0);
    idle(4);
    // single-lane write
    step(1'b0, 1'b0, '1, AW'(7), '0, 1'b1, '0);
    step(1'b0, 1'b0, 16'h0001, AW'(7), '1, 1'b1, '0);
    step(1'b1, 1'b1, '0, '0, '0, 1'b0, AW'(7));
    idle(4);
    // same-address write/read collision
    step(1'b0, 1'b0, '1, AW'(5), {16{8'h11}}, 1'b1, '0);
    step(1'b0, 1'b0, '1, AW'(5), {16{8'h22}}, 1'b0, AW'(5));
    step(1'b1, 1'b1, '0, '0, '0, 1'b0, AW'(5));
    idle(4);
    // masked-off write must not collide
    step(1'b0, 1'b0, '0, AW'(5), '1, 1'b0, AW'(5));
    idle(4);
    // back-to-back burst on port 1
    for (int a = 0; a < 8; a++)
      step(1'b1, 1'b1, '0, '0, '0, 1'b0, AW'(a));
    idle(5);
    // concurrent reads on both ports
    step(1'b0, 1'b1, '0, AW'(1), '0, 1'b0, AW'(2));
    idle(4);
    // reset with reads in flight
    step(1'b1, 1'b1, '0, '0, '0, 1'b0, AW'(1));
    step(1'b0, 1'b1, '0, AW'(2), '0, 1'b1, '0);
    reset_mid();
    step(1'b0, 1'b0, '1, AW'(3), rnd(), 1'b0, AW'(3));
    step(1'b0, 1'b1, '0, AW'(3), '0, 1'b0, AW'(4));
    rstb = 1'b1;
    step(1'b0, 1'b1, '0, AW'(3), '0, 1'b0, AW'(5));
    idle(4);
    repeat (400) rand_step(1'b0);
    idle(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
